// File: rtl/cart_loader.sv
// Cartridge download loader: writes the ioctl image into CPU RAM, mirrors it
// across the cartridge window and holds the console in reset until settled.
module cart_loader #(
  parameter logic [7:0]  CART_INDEX = 8'd1,
  parameter logic [15:0] CART_BASE  = 16'h0000,
  parameter int unsigned WINDOW     = 32768,
  parameter int unsigned HOLD_CYC   = 255
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] ram_a,
  output logic [7:0]  ram_d,
  output logic        ram_we,
  input  logic [7:0]  ram_q,
  output logic        busy,
  output logic        core_reset,
  output logic [16:0] cart_size,
  output logic        oversize
);

  typedef enum logic [2:0] {
    LOAD,
    MRD,
    MWAIT,
    MWR,
    HOLD,
    IDLE
  } state_e;

  localparam logic [16:0] WIN    = 17'(WINDOW);
  localparam logic [24:0] WIN_A  = 25'(WINDOW);
  localparam logic [15:0] HOLD_V = 16'(HOLD_CYC);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [16:0] src_q;
  logic [16:0] dst_q;
  logic [16:0] size_q;
  logic        over_q;
  logic [15:0] ram_a_q;
  logic [7:0]  ram_d_q;
  logic        ram_we_q;
  logic        busy_q;
  logic        core_rst_q;

  logic        cart_dl;
  logic        in_win;
  logic [16:0] end_d;
  logic [16:0] size_d;
  logic [16:0] src_inc;
  logic [16:0] src_d;
  logic [16:0] dst_d;

  always_comb begin
    cart_dl = ioctl_download && (ioctl_index == CART_INDEX);
    in_win  = ioctl_addr < WIN_A;
    end_d   = {1'b0, ioctl_addr[15:0]} + 17'd1;
    size_d  = (end_d > size_q) ? end_d : size_q;
    src_inc = src_q + 17'd1;
    // wrap on the image length so odd sizes repeat seamlessly
    src_d   = (src_inc == size_q) ? 17'd0 : src_inc;
    dst_d   = dst_q + 17'd1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= HOLD;
      cnt_q      <= HOLD_V;
      src_q      <= '0;
      dst_q      <= '0;
      size_q     <= '0;
      over_q     <= 1'b0;
      ram_a_q    <= '0;
      ram_d_q    <= '0;
      ram_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      ram_we_q <= 1'b0;
      if (cart_dl && state_q != LOAD) begin
        state_q    <= LOAD;
        size_q     <= '0;
        over_q     <= 1'b0;
        busy_q     <= 1'b1;
        core_rst_q <= 1'b1;
      end else begin
        unique case (state_q)
          LOAD: begin
            if (!cart_dl) begin
              if (size_q == '0 || size_q == WIN) begin
                state_q <= HOLD;
                cnt_q   <= HOLD_V;
                busy_q  <= 1'b0;
              end else begin
                src_q   <= '0;
                dst_q   <= size_q;
                ram_a_q <= CART_BASE;
                state_q <= MRD;
              end
            end else if (ioctl_wr) begin
              if (in_win) begin
                ram_a_q  <= CART_BASE + ioctl_addr[15:0];
                ram_d_q  <= ioctl_dout;
                ram_we_q <= 1'b1;
                size_q   <= size_d;
              end else begin
                over_q <= 1'b1;
              end
            end
          end
          MRD: state_q <= MWAIT;
          MWAIT: begin
            ram_a_q  <= CART_BASE + dst_q[15:0];
            ram_d_q  <= ram_q;
            ram_we_q <= 1'b1;
            state_q  <= MWR;
          end
          MWR: begin
            src_q <= src_d;
            dst_q <= dst_d;
            if (dst_q == WIN - 17'd1) begin
              state_q <= HOLD;
              cnt_q   <= HOLD_V;
              busy_q  <= 1'b0;
            end else begin
              ram_a_q <= CART_BASE + src_d[15:0];
              state_q <= MRD;
            end
          end
          HOLD: begin
            if (cnt_q == 16'd0) begin
              state_q    <= IDLE;
              core_rst_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
          IDLE: state_q <= IDLE;
          default: begin
            state_q <= HOLD;
            cnt_q   <= HOLD_V;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ram_a      = ram_a_q;
  assign ram_d      = ram_d_q;
  assign ram_we     = ram_we_q;
  assign busy       = busy_q;
  assign core_reset = core_rst_q;
  assign cart_size  = size_q;
  assign oversize   = over_q;

endmodule

// File: tb/tb_cart_loader.sv
// Bench for cart_loader: RAM model plus write scoreboard, with a reduced
// window so full mirror runs stay short.
module tb_cart_loader;

  localparam int          W    = 1024;
  localparam int          HC   = 255;
  localparam logic [15:0] BASE = 16'h0100;
  localparam logic [7:0]  CIDX = 8'd1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dl = 1'b0;
  logic [7:0]  idx = 8'd0;
  logic        wr = 1'b0;
  logic [24:0] addr = '0;
  logic [7:0]  dout = '0;
  logic [15:0] ram_a;
  logic [7:0]  ram_d;
  logic        ram_we;
  logic [7:0]  ram_q = '0;
  logic        busy;
  logic        core_reset;
  logic [16:0] cart_size;
  logic        oversize;

  logic [7:0]  mem [0:65535];
  logic [7:0]  img [0:2047];
  logic [23:0] exp_q [$];
  int          total = 0;
  int          bad = 0;
  int          wr_cnt = 0;

  always #5 clk = ~clk;

  cart_loader #(
    .CART_INDEX(CIDX),
    .CART_BASE (BASE),
    .WINDOW    (W),
    .HOLD_CYC  (HC)
  ) dut (
    .clk_sys       (clk),
    .reset         (reset),
    .ioctl_download(dl),
    .ioctl_index   (idx),
    .ioctl_wr      (wr),
    .ioctl_addr    (addr),
    .ioctl_dout    (dout),
    .ram_a         (ram_a),
    .ram_d         (ram_d),
    .ram_we        (ram_we),
    .ram_q         (ram_q),
    .busy          (busy),
    .core_reset    (core_reset),
    .cart_size     (cart_size),
    .oversize      (oversize)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_d;
    ram_q <= mem[ram_a];
  end

  // every RAM write must match the oldest expected write
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      logic [23:0] e;
      wr_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write a=%h d=%h, none expected", ram_a, ram_d);
      end else begin
        e = exp_q.pop_front();
        if ({ram_a, ram_d} !== e) begin
          bad++;
          $display("FAIL write_seq got a=%h d=%h want a=%h d=%h",
                   ram_a, ram_d, e[23:8], e[7:0]);
        end
      end
    end
  end

  task automatic load(input int n);
    int sz;
    if (!dl) begin
      @(posedge clk); #1;
      dl = 1'b1;
      idx = CIDX;
      @(posedge clk); #1;
    end
    sz = 0;
    for (int a = 0; a < n; a++) begin
      wr = 1'b1;
      addr = 25'(a);
      dout = img[a];
      if (a < W) begin
        exp_q.push_back({16'(BASE + a), img[a]});
        if (a + 1 > sz) sz = a + 1;
      end
      @(posedge clk); #1;
      wr = 1'b0;
      @(posedge clk); #1;
    end
    dl = 1'b0;
    if (sz != 0 && sz != W)
      for (int k = sz; k < W; k++)
        exp_q.push_back({16'(BASE + k), img[k % sz]});
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    int n;
    n = 0;
    while (core_reset === 1'b1 && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (core_reset === 1'b0);
  endtask

  task automatic test_reset;
    int n;
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (core_reset !== 1'b1) begin
      bad++; $display("FAIL rst_core_reset got %b want 1", core_reset);
    end
    total++;
    if ({busy, ram_we, oversize} !== 3'b000) begin
      bad++; $display("FAIL rst_flags got %b want 000", {busy, ram_we, oversize});
    end
    total++;
    if ({ram_a, ram_d, cart_size} !== 41'd0) begin
      bad++; $display("FAIL rst_regs got a=%h d=%h sz=%0d want 0", ram_a, ram_d, cart_size);
    end
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (core_reset !== 1'b1) break;
    end
    total++;
    if (n != HC + 1 || core_reset !== 1'b0) begin
      bad++; $display("FAIL hold_len got %0d cycles want %0d", n, HC + 1);
    end
  endtask

  task automatic test_mirror_pow2;
    int w0;
    bit ok;
    for (int a = 0; a < 512; a++) img[a] = 8'(a) ^ 8'(a >> 8);
    load(512);
    w0 = wr_cnt;
    wait_idle(4 * W + HC + 100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL p2_timeout core_reset=%b want 0", core_reset); end
    total++;
    if (cart_size !== 17'd512) begin
      bad++; $display("FAIL p2_size got %0d want 512", cart_size);
    end
    total++;
    if (wr_cnt - w0 != W - 512) begin
      bad++; $display("FAIL p2_mirror_cnt got %0d want %0d", wr_cnt - w0, W - 512);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL p2_pending got %0d want 0", exp_q.size());
    end
    for (int k = 0; k < W; k++) begin
      total++;
      if (mem[BASE + k] !== img[k % 512]) begin
        bad++; $display("FAIL p2_ram[%0d] got %h want %h", k, mem[BASE + k], img[k % 512]);
      end
    end
  endtask

  task automatic test_small;
    bit ok;
    img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC;
    load(3);
    wait_idle(4 * W + HC + 100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL s3_timeout core_reset=%b want 0", core_reset); end
    total++;
    if (cart_size !== 17'd3 || oversize !== 1'b0) begin
      bad++; $display("FAIL s3_size got %0d/%b want 3/0", cart_size, oversize);
    end
    for (int k = 0; k < W; k++) begin
      total++;
      if (mem[BASE + k] !== img[k % 3]) begin
        bad++; $display("FAIL s3_ram[%0d] got %h want %h", k, mem[BASE + k], img[k % 3]);
      end
    end
  endtask

  task automatic test_oversize;
    int w0;
    bit ok;
    for (int a = 0; a < W + 2; a++) img[a] = 8'($urandom);
    w0 = wr_cnt;
    load(W + 2);
    wait_idle(HC + 100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ov_timeout core_reset=%b want 0", core_reset); end
    total++;
    if (oversize !== 1'b1) begin bad++; $display("FAIL ov_flag got %b want 1", oversize); end
    total++;
    if (cart_size !== 17'(W)) begin
      bad++; $display("FAIL ov_size got %0d want %0d", cart_size, W);
    end
    total++;
    if (wr_cnt - w0 != W) begin
      bad++; $display("FAIL ov_wr_cnt got %0d want %0d", wr_cnt - w0, W);
    end
    total++;
    if (mem[BASE + W] !== 8'hEE || mem[BASE + W + 1] !== 8'hEE) begin
      bad++; $display("FAIL ov_beyond got %h %h want ee ee", mem[BASE + W], mem[BASE + W + 1]);
    end
    for (int k = 0; k < W; k++) begin
      total++;
      if (mem[BASE + k] !== img[k]) begin
        bad++; $display("FAIL ov_ram[%0d] got %h want %h", k, mem[BASE + k], img[k]);
      end
    end
  endtask

  task automatic test_abort;
    bit ok;
    for (int a = 0; a < 100; a++) img[a] = 8'($urandom);
    load(100);
    repeat (200) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL ab_mid got busy=%b want 1", busy); end
    dl = 1'b1;
    idx = CIDX;
    @(posedge clk); #1;
    exp_q.delete();
    total++;
    if (cart_size !== 17'd0 || ram_we !== 1'b0) begin
      bad++; $display("FAIL ab_entry got sz=%0d we=%b want 0/0", cart_size, ram_we);
    end
    total++;
    if (busy !== 1'b1 || core_reset !== 1'b1) begin
      bad++; $display("FAIL ab_state got busy=%b crst=%b want 1/1", busy, core_reset);
    end
    for (int a = 0; a < 32; a++) img[a] = 8'($urandom);
    load(32);
    wait_idle(4 * W + HC + 100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ab_timeout core_reset=%b want 0", core_reset); end
    total++;
    if (cart_size !== 17'd32) begin
      bad++; $display("FAIL ab_size got %0d want 32", cart_size);
    end
    for (int k = 0; k < W; k++) begin
      total++;
      if (mem[BASE + k] !== img[k % 32]) begin
        bad++; $display("FAIL ab_ram[%0d] got %h want %h", k, mem[BASE + k], img[k % 32]);
      end
    end
  endtask

  task automatic test_reset_mid_load;
    bit ok;
    @(posedge clk); #1;
    dl = 1'b1;
    idx = CIDX;
    @(posedge clk); #1;
    wr = 1'b1;
    addr = 25'd5;
    dout = 8'h5A;
    exp_q.push_back({16'(BASE + 5), 8'h5A});
    @(posedge clk); #1;
    wr = 1'b0;
    total++;
    if (ram_we !== 1'b1 || ram_a !== 16'(BASE + 5) || ram_d !== 8'h5A) begin
      bad++; $display("FAIL lat1 got we=%b a=%h d=%h want 1 %h 5a", ram_we, ram_a, ram_d, 16'(BASE + 5));
    end
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    total++;
    if (ram_we !== 1'b0 || busy !== 1'b0 || core_reset !== 1'b1) begin
      bad++; $display("FAIL rml got we=%b busy=%b crst=%b want 0 0 1", ram_we, busy, core_reset);
    end
    total++;
    if (cart_size !== 17'd0) begin
      bad++; $display("FAIL rml_size got %0d want 0", cart_size);
    end
    dl = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wait_idle(HC + 100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rml_timeout core_reset=%b want 0", core_reset); end
  endtask

  task automatic test_other_index;
    @(posedge clk); #1;
    dl = 1'b1;
    idx = 8'd2;
    for (int a = 0; a < 4; a++) begin
      wr = 1'b1;
      addr = 25'(a);
      dout = 8'h77;
      @(posedge clk); #1;
      wr = 1'b0;
      total++;
      if (core_reset !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL idx2 got crst=%b busy=%b want 0 0", core_reset, busy);
      end
      @(posedge clk); #1;
    end
    dl = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (cart_size !== 17'd0 || core_reset !== 1'b0) begin
      bad++; $display("FAIL idx2_end got sz=%0d crst=%b want 0 0", cart_size, core_reset);
    end
    total++;
    if (mem[BASE] !== 8'hEE) begin
      bad++; $display("FAIL idx2_ram got %h want ee", mem[BASE]);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEE;
    test_reset;
    test_mirror_pow2;
    test_small;
    test_oversize;
    test_abort;
    test_reset_mid_load;
    for (int k = 0; k < W; k++) mem[BASE + k] = 8'hEE;
    test_other_index;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
